// File: rtl/lfsr_pkg.sv
// Shared types and the width/mode-generic single-step function
// for the lfsr_gen pseudo-random source.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    // Operands are zero-extended to 64 bits; the caller truncates to its width.
    function automatic logic [63:0] lfsr_next(
        input logic [63:0] cur,
        input logic [63:0] taps,
        input int          width,
        input bit          galois
    );
        logic [63:0] nxt;
        if (galois) begin
            nxt = (cur >> 1) ^ (cur[0] ? taps : 64'd0);
        end else begin
            nxt = (cur >> 1) | ({63'd0, ^(cur & taps)} << (width - 1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR single step; chained STEPS times by lfsr_gen.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 20,
    parameter logic [WIDTH-1:0] TAPS   = 20'h08881,
    parameter bit               GALOIS = 1'b0
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = WIDTH'(lfsr_next(64'(cur), 64'(TAPS), WIDTH, GALOIS));

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR source: free-run or bounded run, seed load,
// zero-state recovery, match pulse and saturating advance counter.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 20,
    parameter logic [WIDTH-1:0] TAPS   = 20'h08881,
    parameter logic [WIDTH-1:0] SEED   = 20'h99999,
    parameter bit               GALOIS = 1'b0,
    parameter int               STEPS  = 1,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run_start,
    input  logic [CNT_W-1:0] run_len,
    input  logic [WIDTH-1:0] match_val,
    output logic [WIDTH-1:0] lfsr,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic             lockup,
    output logic [CNT_W-1:0] step_cnt
);

    run_state_t       state, nxt_state;
    logic [CNT_W-1:0] remaining, nxt_remaining;
    logic [WIDTH-1:0] nxt_lfsr;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_done, nxt_match, nxt_lockup;
    logic             advance;
    logic [WIDTH-1:0] chain [0:STEPS];

    assign chain[0] = lfsr;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .GALOIS(GALOIS)
        ) u_step (
            .cur(chain[i]),
            .nxt(chain[i+1])
        );
    end

    assign busy    = (state == RUN);
    assign advance = en | busy;

    always_comb begin
        nxt_state     = state;
        nxt_remaining = remaining;
        nxt_done      = 1'b0;
        if (load) begin
            nxt_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run_start) begin
                        if (run_len == '0) begin
                            nxt_done = 1'b1;
                        end else begin
                            nxt_remaining = run_len;
                            nxt_state     = RUN;
                        end
                    end
                end
                RUN: begin
                    nxt_remaining = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        nxt_state = IDLE;
                        nxt_done  = 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        nxt_lfsr   = lfsr;
        nxt_cnt    = step_cnt;
        nxt_lockup = lockup;
        nxt_match  = 1'b0;
        if (load) begin
            nxt_lfsr   = load_val;
            nxt_cnt    = '0;
            nxt_lockup = 1'b0;
        end else if (advance) begin
            // A zero state would never leave zero; restart from the seed.
            if (lfsr == '0) begin
                nxt_lfsr   = SEED;
                nxt_lockup = 1'b1;
            end else begin
                nxt_lfsr = chain[STEPS];
            end
            if (step_cnt != '1) begin
                nxt_cnt = step_cnt + CNT_W'(1);
            end
            nxt_match = (nxt_lfsr == match_val);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            lfsr      <= SEED;
            done      <= 1'b0;
            match     <= 1'b0;
            lockup    <= 1'b0;
            step_cnt  <= '0;
        end else begin
            state     <= nxt_state;
            remaining <= nxt_remaining;
            lfsr      <= nxt_lfsr;
            done      <= nxt_done;
            match     <= nxt_match;
            lockup    <= nxt_lockup;
            step_cnt  <= nxt_cnt;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: 20-bit Fibonacci (1 and 2 steps),
// 4-bit Fibonacci and 4-bit Galois instances.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, load, run_start;
    logic [19:0] load_val, match_val;
    logic [15:0] run_len;
    logic [3:0]  load_val4, match_val4, run_len4;

    logic [19:0] a_lfsr, b_lfsr;
    logic [15:0] a_cnt, b_cnt;
    logic        a_busy, a_done, a_match, a_lock;
    logic        b_busy, b_done, b_match, b_lock;
    logic [3:0]  c_lfsr, c_cnt, d_lfsr, d_cnt;
    logic        c_busy, c_done, c_match, c_lock;
    logic        d_busy, d_done, d_match, d_lock;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_gen u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .load_val(load_val), .run_start(run_start), .run_len(run_len),
        .match_val(match_val), .lfsr(a_lfsr), .busy(a_busy),
        .done(a_done), .match(a_match), .lockup(a_lock), .step_cnt(a_cnt)
    );

    lfsr_gen #(.STEPS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .load_val(load_val), .run_start(run_start), .run_len(run_len),
        .match_val(match_val), .lfsr(b_lfsr), .busy(b_busy),
        .done(b_done), .match(b_match), .lockup(b_lock), .step_cnt(b_cnt)
    );

    lfsr_gen #(
        .WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .GALOIS(1'b0), .CNT_W(4)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .load_val(load_val4), .run_start(run_start), .run_len(run_len4),
        .match_val(match_val4), .lfsr(c_lfsr), .busy(c_busy),
        .done(c_done), .match(c_match), .lockup(c_lock), .step_cnt(c_cnt)
    );

    lfsr_gen #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .GALOIS(1'b1), .CNT_W(4)
    ) u_d (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .load_val(load_val4), .run_start(run_start), .run_len(run_len4),
        .match_val(match_val4), .lfsr(d_lfsr), .busy(d_busy),
        .done(d_done), .match(d_match), .lockup(d_lock), .step_cnt(d_cnt)
    );

    typedef struct {
        logic        en, ld, rs;
        logic [19:0] lv;
        logic [15:0] rl;
        logic [19:0] e_lfsr;
        logic        e_busy, e_done, e_match, e_lock;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [3:0] e_c, e_d, e_cnt;
        logic       e_match;
    } small_t;

    vec_t   vec [19];
    vec_t   sbq [$];
    small_t sbq4 [$];

    function automatic vec_t mk(int i_en, int i_ld, int i_rs, int lv, int rl,
                                int el, int eb, int ed, int em, int elk,
                                int ec);
        vec_t v;
        v.en      = i_en[0];
        v.ld      = i_ld[0];
        v.rs      = i_rs[0];
        v.lv      = lv[19:0];
        v.rl      = rl[15:0];
        v.e_lfsr  = el[19:0];
        v.e_busy  = eb[0];
        v.e_done  = ed[0];
        v.e_match = em[0];
        v.e_lock  = elk[0];
        v.e_cnt   = ec[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        en = 0; load = 0; run_start = 0;
        load_val = '0; run_len = '0; load_val4 = '0; run_len4 = '0;
    endtask

    logic [3:0] fib_seq [15];
    logic [3:0] gal_seq [15];

    initial begin
        vec_t   e;
        small_t s;

        //         en ld rs lv       rl  lfsr     b  d  m  lk cnt
        vec[0]  = mk(1, 0, 0, 0,       0, 'h4CCCC, 0, 0, 0, 0, 1);
        vec[1]  = mk(1, 0, 0, 0,       0, 'hA6666, 0, 0, 1, 0, 2);
        vec[2]  = mk(0, 0, 0, 0,       0, 'hA6666, 0, 0, 0, 0, 2);
        vec[3]  = mk(0, 1, 0, 0,       0, 'h00000, 0, 0, 0, 0, 0);
        vec[4]  = mk(1, 0, 0, 0,       0, 'h99999, 0, 0, 0, 1, 1);
        vec[5]  = mk(1, 0, 0, 0,       0, 'h4CCCC, 0, 0, 0, 1, 2);
        vec[6]  = mk(0, 1, 0, 'h12345, 0, 'h12345, 0, 0, 0, 0, 0);
        vec[7]  = mk(0, 1, 0, 'h99999, 0, 'h99999, 0, 0, 0, 0, 0);
        vec[8]  = mk(0, 0, 1, 0,       3, 'h99999, 1, 0, 0, 0, 0);
        vec[9]  = mk(0, 0, 1, 0,       9, 'h4CCCC, 1, 0, 0, 0, 1);
        vec[10] = mk(1, 0, 0, 0,       0, 'hA6666, 1, 0, 1, 0, 2);
        vec[11] = mk(0, 0, 0, 0,       0, 'h53333, 0, 1, 0, 0, 3);
        vec[12] = mk(0, 0, 0, 0,       0, 'h53333, 0, 0, 0, 0, 3);
        vec[13] = mk(0, 0, 1, 0,       0, 'h53333, 0, 1, 0, 0, 3);
        vec[14] = mk(0, 0, 0, 0,       0, 'h53333, 0, 0, 0, 0, 3);
        vec[15] = mk(0, 0, 1, 0,       5, 'h53333, 1, 0, 0, 0, 3);
        vec[16] = mk(0, 0, 0, 0,       0, 'hA9999, 1, 0, 0, 0, 4);
        vec[17] = mk(0, 1, 0, 'h00001, 0, 'h00001, 0, 0, 0, 0, 0);
        vec[18] = mk(0, 0, 0, 0,       0, 'h00001, 0, 0, 0, 0, 0);

        fib_seq = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                    4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
        gal_seq = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                    4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

        // Phase 1: 20-bit Fibonacci, table-driven
        rst_n = 0;
        idle_inputs();
        match_val  = 20'hA6666;
        match_val4 = 4'h1;
        repeat (2) @(negedge clk);
        chk("reset_lfsr", 64'(a_lfsr), 64'h99999);
        rst_n = 1;
        @(negedge clk);
        chk("reset_lfsr_rel", 64'(a_lfsr), 64'h99999);
        chk("reset_busy", 64'(a_busy), 0);
        chk("reset_done", 64'(a_done), 0);
        chk("reset_match", 64'(a_match), 0);
        chk("reset_lock", 64'(a_lock), 0);
        chk("reset_cnt", 64'(a_cnt), 0);

        for (int i = 0; i < 19; i++) begin
            en        = vec[i].en;
            load      = vec[i].ld;
            run_start = vec[i].rs;
            load_val  = vec[i].lv;
            run_len   = vec[i].rl;
            sbq.push_back(vec[i]);
            @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("v%0d_lfsr", i), 64'(a_lfsr), 64'(e.e_lfsr));
            chk($sformatf("v%0d_busy", i), 64'(a_busy), 64'(e.e_busy));
            chk($sformatf("v%0d_done", i), 64'(a_done), 64'(e.e_done));
            chk($sformatf("v%0d_match", i), 64'(a_match), 64'(e.e_match));
            chk($sformatf("v%0d_lock", i), 64'(a_lock), 64'(e.e_lock));
            chk($sformatf("v%0d_cnt", i), 64'(a_cnt), 64'(e.e_cnt));
            if (i == 0) begin
                chk("steps2_lfsr", 64'(b_lfsr), 64'hA6666);
                chk("steps2_cnt", 64'(b_cnt), 1);
            end
        end

        // Async reset in the middle of a run on the 20-bit instance
        idle_inputs();
        run_start = 1;
        run_len   = 16'd6;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        chk("pre_arst_busy", 64'(a_busy), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_lfsr", 64'(a_lfsr), 64'h99999);
        chk("arst_busy", 64'(a_busy), 0);
        chk("arst_cnt", 64'(a_cnt), 0);
        @(negedge clk);
        chk("arst_no_done", 64'(a_done), 0);

        // Phase 2: 4-bit Fibonacci and Galois period, match, saturation
        rst_n = 1;
        @(negedge clk);
        chk("c_reset", 64'(c_lfsr), 1);
        chk("d_reset", 64'(d_lfsr), 1);
        for (int k = 0; k < 30; k++) begin
            en     = 1;
            s.e_c  = fib_seq[k % 15];
            s.e_d  = gal_seq[k % 15];
            s.e_match = ((k % 15) == 14);
            s.e_cnt   = (k >= 14) ? 4'hF : 4'(k + 1);
            sbq4.push_back(s);
            @(posedge clk);
            @(negedge clk);
            s = sbq4.pop_front();
            chk($sformatf("fib_%0d", k), 64'(c_lfsr), 64'(s.e_c));
            chk($sformatf("gal_%0d", k), 64'(d_lfsr), 64'(s.e_d));
            chk($sformatf("fib_m%0d", k), 64'(c_match), 64'(s.e_match));
            chk($sformatf("gal_m%0d", k), 64'(d_match), 64'(s.e_match));
            chk($sformatf("fib_c%0d", k), 64'(c_cnt), 64'(s.e_cnt));
        end

        // Galois instance: async reset mid-run
        idle_inputs();
        run_start = 1;
        run_len4  = 4'd6;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("gal_run_busy", 64'(d_busy), 1);
        #3 rst_n = 0;
        #1;
        chk("gal_arst_lfsr", 64'(d_lfsr), 1);
        chk("gal_arst_busy", 64'(d_busy), 0);
        chk("gal_arst_cnt", 64'(d_cnt), 0);
        @(negedge clk);
        chk("gal_arst_done", 64'(d_done), 0);
        rst_n = 1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
